data_ram_mmio: RTL

Data-side memory responder for the five-stage RISC-V core. It answers the core's data-RAM port (chip enable, write enable, byte-lane select, address and write data out of the MEM stage) with same-cycle read data and registered byte-lane writes. The upper 64 KiB of the address space is a small memory-mapped I/O window. It holds a console transmit FIFO with a valid/ready drain port and a 64-bit free-running cycle counter with coherent high-word reads. The block sits beside the core at top level, opposite the instruction ROM.

---
 rtl/data_ram_mmio_if.sv | 20 ++
 rtl/data_ram_mmio.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram_mmio_if.sv
// Data-port bus between the core's MEM stage and the data RAM / MMIO responder.
// The core drives the request fields and the responder returns same-cycle read data.
interface data_ram_mmio_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o
  );
endinterface

// File: rtl/data_ram_mmio.sv
// Data-side RAM with byte-lane writes plus an MMIO window at 0xFFFF_xxxx holding
// a console TX FIFO (valid/ready drain) and a 64-bit cycle counter with a coherent high-word shadow.
module data_ram_mmio #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_mmio_if.slave       bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RAM_WORDS = 2 ** ADDR_WIDTH;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [13:0] OFF_TXDATA = 14'd0;
  localparam logic [13:0] OFF_STATUS = 14'd1;
  localparam logic [13:0] OFF_CYC_LO = 14'd2;
  localparam logic [13:0] OFF_CYC_HI = 14'd3;

  // STATUS layout; the occupancy field saturates at 15 so deep FIFOs still fit 4 bits.
  function automatic logic [31:0] status_word(
    input logic [CNT_W-1:0] cnt,
    input logic             ovf,
    input logic             full,
    input logic             empty
  );
    logic [31:0] wide;
    logic [3:0]  cnt4;
    wide = 32'(cnt);
    if (wide > 32'd15) begin
      cnt4 = 4'hF;
    end else begin
      cnt4 = wide[3:0];
    end
    return {20'h0_0000, cnt4, 5'b0_0000, ovf, full, empty};
  endfunction

  logic [31:0]           ram_r [RAM_WORDS];
  logic [7:0]            fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  overflow_r;
  logic [63:0]           cycle_r;
  logic [31:0]           shadow_r;

  logic                  mmio_s;
  logic [13:0]           off_s;
  logic [ADDR_WIDTH-1:0] word_s;
  logic                  rd_s;
  logic                  wr_s;
  logic                  ram_wr_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_req_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_set_s;
  logic                  ovf_clr_s;
  logic                  lo_rd_s;
  logic [31:0]           rdata_s;
  logic                  unused_s;

  assign mmio_s   = (bus.addr[31:16] == 16'hFFFF);
  assign off_s    = bus.addr[15:2];
  assign word_s   = bus.addr[ADDR_WIDTH+1:2];
  assign rd_s     = bus.ce & ~bus.we;
  assign wr_s     = bus.ce & bus.we;
  assign ram_wr_s = wr_s & ~mmio_s;
  assign unused_s = ^bus.addr[1:0];

  assign full_s     = (count_r == DEPTH_C);
  assign empty_s    = (count_r == CNT_ZERO);
  assign pop_s      = ~empty_s & tx_ready;
  assign push_req_s = wr_s & mmio_s & (off_s == OFF_TXDATA) & bus.sel[0];
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign ovf_set_s  = push_req_s & full_s & ~pop_s;
  assign ovf_clr_s  = wr_s & mmio_s & (off_s == OFF_STATUS) & bus.sel[0] & bus.data_i[2];
  assign lo_rd_s    = rd_s & mmio_s & (off_s == OFF_CYC_LO);

  assign tx_valid = ~empty_s;

  // Head byte is gated to zero while empty so stale storage never shows on the port.
  always_comb begin
    tx_data = 8'h00;
    if (!empty_s) begin
      tx_data = fifo_mem_r[rd_ptr_r];
    end else begin
      tx_data = 8'h00;
    end
  end

  // Same-cycle read mux: RAM word or MMIO register, zero for idle, write or unmapped.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (rd_s) begin
      if (mmio_s) begin
        case (off_s)
          OFF_TXDATA: rdata_s = 32'h0000_0000;
          OFF_STATUS: rdata_s = status_word(count_r, overflow_r, full_s, empty_s);
          OFF_CYC_LO: rdata_s = cycle_r[31:0];
          OFF_CYC_HI: rdata_s = shadow_r;
          default:    rdata_s = 32'h0000_0000;
        endcase
      end else begin
        rdata_s = ram_r[word_s];
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.data_o = rdata_s;

  // Byte-lane RAM writes; no reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sel[i]) begin
          ram_r[word_s][8*i +: 8] <= bus.data_i[8*i +: 8];
        end
      end
    end
  end

  // FIFO storage; entries are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.data_i[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A fresh overflow outranks a clear issued in the same cycle.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Free-running cycle counter and the high-word shadow latched by CYCLE_LO reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_r  <= 64'h0;
      shadow_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (lo_rd_s) begin
        shadow_r <= cycle_r[63:32];
      end
    end
  end

endmodule
